// File: rtl/countdown_timer.sv
// Programmable down-counting timer with prescaler, one-shot/periodic modes and sticky expiry flag.
// Optional sticky overrun detection is enabled by defining TIMER_OVERRUN_EN.
module countdown_timer #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1
) (
  input  logic             GlobalClock,
  input  logic             clear_n,
  input  logic             ClockEnable,
  input  logic [WIDTH-1:0] LoadData,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] CountValue,
  output logic             Expired,
  output logic             Busy,
  output logic             Overrun
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [PW-1:0]    prescale_q, prescale_d;
  logic             periodicMode_q, periodicMode_d;
  logic             expired_q, expired_d;
  logic             loadAccept;
  logic             expire;
  logic [WIDTH-1:0] effCount;

  assign load_ready = (state_q != RUN);
  assign Busy       = (state_q == RUN);
  assign CountValue = count_q;
  assign Expired    = expired_q;
  assign loadAccept = load_valid & load_ready;
  assign effCount   = loadAccept ? LoadData : count_q;

  // stop outranks everything in RUN; a zero effective count makes start a no-op
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    reload_d       = reload_q;
    prescale_d     = prescale_q;
    periodicMode_d = periodicMode_q;
    expire         = 1'b0;

    if (state_q != RUN) begin
      if (loadAccept) begin
        reload_d   = LoadData;
        count_d    = LoadData;
        prescale_d = '0;
      end
      if (start && (effCount != '0)) begin
        state_d        = RUN;
        prescale_d     = '0;
        periodicMode_d = periodic;
      end
    end else if (stop) begin
      state_d    = IDLE;
      prescale_d = '0;
    end else if (ClockEnable) begin
      if (prescale_q == PRESC_LAST) begin
        prescale_d = '0;
        if (count_q > WIDTH'(1)) begin
          count_d = count_q - WIDTH'(1);
        end else if (count_q == WIDTH'(1)) begin
          expire = 1'b1;
          if (periodicMode_q) begin
            count_d = reload_q;
          end else begin
            count_d = '0;
            state_d = DONE;
          end
        end
      end else begin
        prescale_d = prescale_q + PW'(1);
      end
    end

    // a same-cycle expiry beats the acknowledge
    if (expire) begin
      expired_d = 1'b1;
    end else if (irq_ack) begin
      expired_d = 1'b0;
    end else begin
      expired_d = expired_q;
    end
  end

  always_ff @(posedge GlobalClock or negedge clear_n) begin
    if (!clear_n) begin
      state_q        <= IDLE;
      count_q        <= '0;
      reload_q       <= '0;
      prescale_q     <= '0;
      periodicMode_q <= 1'b0;
      expired_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      reload_q       <= reload_d;
      prescale_q     <= prescale_d;
      periodicMode_q <= periodicMode_d;
      expired_q      <= expired_d;
    end
  end

`ifdef TIMER_OVERRUN_EN
  logic overrun_q, overrun_d;

  // overrun means a second expiry landed before software acknowledged the first
  always_comb begin
    overrun_d = overrun_q;
    if (expire && expired_q && !irq_ack) begin
      overrun_d = 1'b1;
    end else if (irq_ack) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge GlobalClock or negedge clear_n) begin
    if (!clear_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign Overrun = overrun_q;
`else
  assign Overrun = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: two instances (PRESCALE 1 and 3) share stimulus,
// a tick-counting reference model queues expected outputs and a monitor compares them.
module tb_countdown_timer;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         exp;
    logic         busy;
    logic         rdy;
    logic         ovr;
  } expT;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         clear_n;
  logic         ce, loadValid, startIn, stopIn, periodicIn, irqAck;
  logic [W-1:0] loadData;

  logic [W-1:0] cv0, cv1;
  logic         exp0, exp1, busy0, busy1, rdy0, rdy1, ovr0, ovr1;

  int total = 0;
  int bad   = 0;

  expT expQ0[$];
  expT expQ1[$];

  // reference model: running flag plus enabled ticks since the last decrement
  bit mRun    [2];
  bit mPer    [2];
  bit mExp    [2];
  bit mOvr    [2];
  int mCount  [2];
  int mReload [2];
  int mTicks  [2];

  countdown_timer #(.WIDTH(W), .PRESCALE(1)) dut0 (
    .GlobalClock(clock), .clear_n(clear_n), .ClockEnable(ce), .LoadData(loadData),
    .load_valid(loadValid), .load_ready(rdy0), .start(startIn), .stop(stopIn),
    .periodic(periodicIn), .irq_ack(irqAck), .CountValue(cv0), .Expired(exp0),
    .Busy(busy0), .Overrun(ovr0)
  );

  countdown_timer #(.WIDTH(W), .PRESCALE(3)) dut1 (
    .GlobalClock(clock), .clear_n(clear_n), .ClockEnable(ce), .LoadData(loadData),
    .load_valid(loadValid), .load_ready(rdy1), .start(startIn), .stop(stopIn),
    .periodic(periodicIn), .irq_ack(irqAck), .CountValue(cv1), .Expired(exp1),
    .Busy(busy1), .Overrun(ovr1)
  );

  function automatic int prescaleOf(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic void modelReset();
    for (int k = 0; k < 2; k++) begin
      mRun[k] = 0; mPer[k] = 0; mExp[k] = 0; mOvr[k] = 0;
      mCount[k] = 0; mReload[k] = 0; mTicks[k] = 0;
    end
  endfunction

  function automatic expT modelStep(int k);
    expT e;
    bit fired = 0;
    if (!mRun[k]) begin
      if (loadValid) begin
        mReload[k] = int'(loadData);
        mCount[k]  = int'(loadData);
        mTicks[k]  = 0;
      end
      if (startIn && mCount[k] != 0) begin
        mRun[k]   = 1;
        mTicks[k] = 0;
        mPer[k]   = periodicIn;
      end
    end else if (stopIn) begin
      mRun[k]   = 0;
      mTicks[k] = 0;
    end else if (ce) begin
      mTicks[k]++;
      if (mTicks[k] == prescaleOf(k)) begin
        mTicks[k] = 0;
        if (mCount[k] > 1) begin
          mCount[k]--;
        end else begin
          fired = 1;
          if (mPer[k]) begin
            mCount[k] = mReload[k];
          end else begin
            mCount[k] = 0;
            mRun[k]   = 0;
          end
        end
      end
    end
`ifdef TIMER_OVERRUN_EN
    if (fired && mExp[k] && !irqAck) mOvr[k] = 1;
    else if (irqAck) mOvr[k] = 0;
`endif
    if (fired) mExp[k] = 1;
    else if (irqAck) mExp[k] = 0;
    e.cnt  = W'(mCount[k]);
    e.exp  = mExp[k];
    e.busy = mRun[k];
    e.rdy  = !mRun[k];
    e.ovr  = mOvr[k];
    return e;
  endfunction

  task automatic compareVal(input string name, input int k, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s dut%0d at %0t: got %0d expected %0d", name, k, $time, act, req);
    end
  endtask

  task automatic checkOutput(input int k, input expT e);
    compareVal("CountValue", k, (k == 0) ? int'(cv0) : int'(cv1), int'(e.cnt));
    compareVal("Expired", k, (k == 0) ? int'(exp0) : int'(exp1), int'(e.exp));
    compareVal("Busy", k, (k == 0) ? int'(busy0) : int'(busy1), int'(e.busy));
    compareVal("load_ready", k, (k == 0) ? int'(rdy0) : int'(rdy1), int'(e.rdy));
    compareVal("Overrun", k, (k == 0) ? int'(ovr0) : int'(ovr1), int'(e.ovr));
  endtask

  task automatic checkResetValues();
    for (int k = 0; k < 2; k++) begin
      expT r;
      r.cnt = '0; r.exp = 1'b0; r.busy = 1'b0; r.rdy = 1'b1; r.ovr = 1'b0;
      checkOutput(k, r);
    end
  endtask

  // one cycle of stimulus: drive, predict, queue expectations, advance past the edge
  task automatic applyStimulus(input bit lv, input int ld, input bit st, input bit sp,
                               input bit per, input bit ack, input bit en);
    loadValid  = lv;
    loadData   = W'(ld);
    startIn    = st;
    stopIn     = sp;
    periodicIn = per;
    irqAck     = ack;
    ce         = en;
    expQ0.push_back(modelStep(0));
    expQ1.push_back(modelStep(1));
    @(posedge clock);
    #2;
  endtask

  task automatic idleCycles(input int n, input bit en);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, en);
  endtask

  task automatic pulseReset();
    #2;
    clear_n = 1'b0;
    loadValid = 0; startIn = 0; stopIn = 0; irqAck = 0; ce = 0;
    #1;
    checkResetValues();
    modelReset();
    @(posedge clock);
    #2;
    clear_n = 1'b1;
  endtask

  always begin
    @(posedge clock);
    #1;
    if (expQ0.size() > 0) checkOutput(0, expQ0.pop_front());
    if (expQ1.size() > 0) checkOutput(1, expQ1.pop_front());
  end

  initial begin
    clear_n = 1'b0;
    loadValid = 0; loadData = '0; startIn = 0; stopIn = 0;
    periodicIn = 0; irqAck = 0; ce = 0;
    modelReset();
    #12;
    checkResetValues();
    @(posedge clock);
    #2;
    clear_n = 1'b1;

    // one-shot from 5
    applyStimulus(1, 5, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 0, 1);
    idleCycles(17, 1);

    // periodic reload of 2, ack colliding with and following expiries
    applyStimulus(1, 2, 1, 0, 1, 0, 1);
    idleCycles(5, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    idleCycles(12, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 1);

    // gated ticks, stop, resume
    applyStimulus(1, 6, 1, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0, 0, i[0]);
    applyStimulus(0, 0, 0, 1, 0, 0, 1);
    idleCycles(3, 1);
    applyStimulus(0, 0, 1, 0, 0, 0, 1);
    idleCycles(20, 1);

    // zero start, load plus zero start, blocked load while running
    applyStimulus(1, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 1, 0, 0, 0, 1);
    applyStimulus(1, 0, 1, 0, 1, 0, 1);
    applyStimulus(1, 4, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 9, 0, 0, 0, 0, 1);
    idleCycles(12, 1);

    pulseReset();

    for (int i = 0; i < 1500; i++) begin
      if (i % 500 == 300) pulseReset();
      applyStimulus($urandom_range(0, 4) == 0, int'($urandom_range(0, 12)),
                    $urandom_range(0, 6) == 0, $urandom_range(0, 24) == 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 9) < 7);
    end

    #5;
    compareVal("queue0_drained", 0, expQ0.size(), 0);
    compareVal("queue1_drained", 1, expQ1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
